// File: rtl/instruction_fetch_unit.sv
// Fetch stage for the 16-bit MIPS core: owns the fetch PC, issues one word read
// at a time to instruction memory and queues the returned words in a small
// prefetch FIFO that feeds decode over a valid/ready handshake.
//
// state | meaning
// IDLE  | no read outstanding; issues the next read when the FIFO has room
// REQ   | read to fpc outstanding; data is pushed when it is acknowledged
// FLUSH | read outstanding but a jump arrived; its data is discarded
module instruction_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter logic [15:0] PC_WRAP  = 16'd30,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [15:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [15:0]   imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [15:0]   inst_out,
    output logic [15:0]   inst_pc,
    input  logic          jump,
    input  logic [15:0]   jump_address,
    output logic [CW-1:0] fifo_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   fifo_pc   [DEPTH];
    logic [15:0]   fifo_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic [15:0]   fpc;
    logic [15:0]   fpc_next;
    logic [15:0]   jump_target;
    logic          pop;
    logic          push;
    logic          has_room;

    assign inst_valid      = (count != '0);
    assign pop             = inst_valid && inst_ready;
    // A jump in the ack cycle makes the returned word stale, so it is dropped.
    assign push            = (state == REQ) && imem_ack && !jump;
    assign count_after_pop = count - CW'(pop);
    assign has_room        = (count_after_pop < CW'(DEPTH));
    assign fpc_next        = (fpc >= PC_WRAP) ? RESET_PC : fpc + PC_STEP;
    assign jump_target     = jump_address & 16'hFFFE;
    assign inst_out        = inst_valid ? fifo_inst[rd_ptr] : 16'h0000;
    assign inst_pc         = inst_valid ? fifo_pc[rd_ptr]   : 16'h0000;
    assign fifo_count      = count;

    // FIFO storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fpc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    // FIFO pointers and occupancy; a jump empties the queue over any push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jump) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Fetch PC: redirected by jump, otherwise advanced only by a kept word.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc <= RESET_PC;
        end else if (jump) begin
            fpc <= jump_target;
        end else if (push) begin
            fpc <= fpc_next;
        end
    end

    // Request FSM with registered imem_req/imem_addr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (!jump && has_room) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= fpc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end else if (jump) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (imem_ack) begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, back-pressure, jumps
// in each state, jump coinciding with ack, and reset with a read in flight.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic        jump;
    logic [15:0] jump_address;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    bit auto_mem = 1'b0;

    instruction_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .jump         (jump),
        .jump_address (jump_address),
        .fifo_count   (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA500 + a;
    endfunction

    // Advance one clock; with auto_mem set, model a zero-wait memory that
    // acks in the same cycle it sees a fresh request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (imem_req && !imem_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 16'h0000;
            end
        end
    endtask

    task automatic do_reset();
        auto_mem   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        jump       = 1'b0;
        rst        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0; inst_ready = 1'b0;
        jump = 1'b0; jump_address = 16'h0;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        total++; if (inst_out !== 16'h0000) begin bad++; $display("FAIL reset_inst_out: got %h expected 0000", inst_out); end
        total++; if (inst_pc !== 16'h0000) begin bad++; $display("FAIL reset_inst_pc: got %h expected 0000", inst_pc); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        int n, last_cyc;
        do_reset();
        inst_ready = 1'b1;
        auto_mem   = 1'b1;
        exp_pc = 16'h0000; n = 0; last_cyc = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            tick();
            if (inst_valid) begin
                total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL stream_pc[%0d]: got %h expected %h", n, inst_pc, exp_pc); end
                total++; if (inst_out !== mem_word(exp_pc)) begin bad++; $display("FAIL stream_inst[%0d]: got %h expected %h", n, inst_out, mem_word(exp_pc)); end
                exp_pc = (exp_pc >= 16'd30) ? 16'h0000 : exp_pc + 16'd2;
                n++;
                last_cyc = cyc;
                if (n == 17) break;
            end
        end
        total++; if (n != 17) begin bad++; $display("FAIL stream_timeout: got %0d instructions expected 17", n); end
        total++; if (last_cyc != 34) begin bad++; $display("FAIL stream_rate: 17th instruction at cycle %0d expected 34", last_cyc); end
    endtask

    task automatic test_backpressure();
        logic [2:0]  prev;
        logic [15:0] exp_pc;
        int n;
        bit seen_req;
        do_reset();
        inst_ready = 1'b0;
        auto_mem   = 1'b1;
        prev = 3'd0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            tick();
            if (fifo_count !== prev) begin
                total++; if (fifo_count !== prev + 3'd1) begin bad++; $display("FAIL bp_count_step: got %0d expected %0d", fifo_count, prev + 3'd1); end
                prev = fifo_count;
            end
        end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL bp_full: got %0d expected 4", fifo_count); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_held_off: got %b expected 0", imem_req); end
        inst_ready = 1'b1;
        exp_pc = 16'h0000; n = 0; seen_req = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            if (inst_valid) begin
                total++; if (inst_pc !== exp_pc) begin bad++; $display("FAIL bp_pop_pc[%0d]: got %h expected %h", n, inst_pc, exp_pc); end
                total++; if (inst_out !== mem_word(exp_pc)) begin bad++; $display("FAIL bp_pop_inst[%0d]: got %h expected %h", n, inst_out, mem_word(exp_pc)); end
                exp_pc = exp_pc + 16'd2;
                n++;
            end
            if (imem_req && !seen_req) begin
                seen_req = 1'b1;
                total++; if (imem_addr !== 16'h0008) begin bad++; $display("FAIL bp_resume_addr: got %h expected 0008", imem_addr); end
            end
            tick();
        end
        total++; if (n != 5 || !seen_req) begin bad++; $display("FAIL bp_timeout: got %0d pops req_seen=%b expected 5 and 1", n, seen_req); end
    endtask

    task automatic test_jump_idle();
        bit got;
        do_reset();
        inst_ready = 1'b0;
        auto_mem   = 1'b1;
        got = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (fifo_count == 3'd3) begin got = 1'b1; break; end
        end
        total++; if (!got) begin bad++; $display("FAIL ji_fill_timeout: count %0d expected 3", fifo_count); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL ji_no_req: got %b expected 0", imem_req); end
        jump = 1'b1; jump_address = 16'h0015;
        tick();
        jump = 1'b0;
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL ji_count: got %0d expected 0", fifo_count); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ji_valid: got %b expected 0", inst_valid); end
        total++; if (inst_out !== 16'h0000) begin bad++; $display("FAIL ji_inst_out: got %h expected 0000", inst_out); end
        got = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (imem_req) begin got = 1'b1; break; end
        end
        total++; if (!got || imem_addr !== 16'h0014) begin bad++; $display("FAIL ji_target_addr: got %h req=%b expected 0014", imem_addr, got); end
        got = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (inst_valid) begin got = 1'b1; break; end
        end
        total++; if (!got || inst_pc !== 16'h0014 || inst_out !== mem_word(16'h0014)) begin bad++; $display("FAIL ji_target_data: got pc %h inst %h expected 0014 %h", inst_pc, inst_out, mem_word(16'h0014)); end
    endtask

    task automatic test_jump_req();
        bit got;
        do_reset();
        inst_ready = 1'b1;
        got = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (imem_req) begin got = 1'b1; break; end
        end
        total++; if (!got || imem_addr !== 16'h0000) begin bad++; $display("FAIL jr_first_req: got %h req=%b expected 0000", imem_addr, got); end
        jump = 1'b1; jump_address = 16'h000A;
        tick();
        jump_address = 16'h000D;
        tick();
        jump = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL jr_flush_hold: got req %b addr %h expected 1 0000", imem_req, imem_addr); end
        tick();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL jr_flush_valid: got %b expected 0", inst_valid); end
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        tick();
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        total++; if (imem_req !== 1'b0 || fifo_count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL jr_discard: got req %b count %0d valid %b expected 0 0 0", imem_req, fifo_count, inst_valid); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h000C) begin bad++; $display("FAIL jr_target_addr: got req %b addr %h expected 1 000c", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = mem_word(16'h000C);
        tick();
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 16'h000C || inst_out !== mem_word(16'h000C)) begin bad++; $display("FAIL jr_target_data: got valid %b pc %h inst %h expected 1 000c %h", inst_valid, inst_pc, inst_out, mem_word(16'h000C)); end
    endtask

    task automatic test_jump_ack();
        bit got;
        do_reset();
        inst_ready = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (imem_req) begin got = 1'b1; break; end
        end
        total++; if (!got) begin bad++; $display("FAIL ja_req_timeout: got req %b expected 1", imem_req); end
        imem_ack = 1'b1; imem_rdata = 16'hBEEF; jump = 1'b1; jump_address = 16'h001C;
        tick();
        imem_ack = 1'b0; imem_rdata = 16'h0000; jump = 1'b0;
        total++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL ja_no_push: got count %0d valid %b req %b expected 0 0 0", fifo_count, inst_valid, imem_req); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h001C) begin bad++; $display("FAIL ja_target_addr: got req %b addr %h expected 1 001c", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = mem_word(16'h001C);
        tick();
        imem_ack = 1'b0;
        total++; if (fifo_count !== 3'd1 || inst_pc !== 16'h001C || inst_out !== mem_word(16'h001C)) begin bad++; $display("FAIL ja_target_data: got count %0d pc %h inst %h expected 1 001c %h", fifo_count, inst_pc, inst_out, mem_word(16'h001C)); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h001E) begin bad++; $display("FAIL ja_last_addr: got req %b addr %h expected 1 001e", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = mem_word(16'h001E);
        tick();
        imem_ack = 1'b0;
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL ja_count2: got %0d expected 2", fifo_count); end
        tick();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL ja_wrap_addr: got req %b addr %h expected 1 0000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_midreq();
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rm_pre_req: got %b expected 1", imem_req); end
        rst = 1'b1;
        tick();
        total++; if (imem_req !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL rm_req_drop: got req %b count %0d expected 0 0", imem_req, fifo_count); end
        tick();
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h5555;
        tick();
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        total++; if (fifo_count !== 3'd0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rm_stray_ack: got count %0d valid %b expected 0 0", fifo_count, inst_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL rm_new_req: got req %b addr %h expected 1 0000", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0000);
        tick();
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000 || inst_out !== mem_word(16'h0000)) begin bad++; $display("FAIL rm_first_data: got valid %b pc %h inst %h expected 1 0000 %h", inst_valid, inst_pc, inst_out, mem_word(16'h0000)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_idle();
        test_jump_req();
        test_jump_ack();
        test_reset_midreq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
